// File: rtl/epw22_cmd_issuer_pkg.sv
// Shared definitions for the EPW22 command issuer.
//   - bus widths of the ALU op/data/tag interface
//   - opcode enumeration and opcode class helpers
//   - cmd_t: one buffered upstream command
//   - state_e: issue FSM states
package epw22_cmd_issuer_pkg;

   localparam int OP_W   = 4;
   localparam int DATA_W = 16;
   localparam int TAG_W  = 2;

   typedef enum logic [OP_W-1:0] {
      NOP      = 4'h0,
      SOFT_RST = 4'h1,
      LOAD     = 4'h2,
      ADD      = 4'h3,
      SUB      = 4'h4,
      RSV5     = 4'h5,
      RSV6     = 4'h6,
      RSV7     = 4'h7,
      MUL      = 4'h8,
      MAC      = 4'h9,
      CMP      = 4'hA,
      READ_ACC = 4'hB,
      AND_OP   = 4'hC,
      OR_OP    = 4'hD,
      XOR_OP   = 4'hE,
      REG_XLAT = 4'hF
   } epw22_op_e;

   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BEAT_A,
      ST_STALL_B,
      ST_BEAT_B
   } state_e;

   // Ops that carry operand B in a second beat.
   function automatic logic is_two_beat(input logic [OP_W-1:0] op);
      case (op)
         ADD, SUB, MUL, MAC, CMP, AND_OP, OR_OP, XOR_OP: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   // Ops for which the ALU later returns a result (duv_valid pulse).
   function automatic logic is_result_op(input logic [OP_W-1:0] op);
      case (op)
         MUL, MAC, CMP, READ_ACC: return 1'b1;
         default:                 return 1'b0;
      endcase
   endfunction

   // Opcodes the ALU does not implement; these are dropped at the input.
   function automatic logic is_reserved(input logic [OP_W-1:0] op);
      case (op)
         RSV5, RSV6, RSV7: return 1'b1;
         default:          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/epw22_cmd_issuer_if.sv
// Signal bundle between the issuer and its surroundings.
//   Command port : cmd_valid/cmd_ready handshake with cmd_op, cmd_tag,
//                  cmd_a, cmd_b.
//   ALU bus      : op/data/tag driven towards the ALU, duv_ready,
//                  duv_valid, duv_error coming back.
// Modports:
//   master - the issuer (answers the command handshake, drives the ALU bus)
//   slave  - the surrounding system (command producer plus ALU)
interface epw22_cmd_issuer_if;
   import epw22_cmd_issuer_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [TAG_W-1:0]  cmd_tag;
   logic [DATA_W-1:0] cmd_a;
   logic [DATA_W-1:0] cmd_b;

   logic [OP_W-1:0]   op;
   logic [DATA_W-1:0] data;
   logic [TAG_W-1:0]  tag;
   logic              duv_ready;
   logic              duv_valid;
   logic              duv_error;

   modport master (
      input  cmd_valid, cmd_op, cmd_tag, cmd_a, cmd_b,
      output cmd_ready,
      output op, data, tag,
      input  duv_ready, duv_valid, duv_error
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_tag, cmd_a, cmd_b,
      input  cmd_ready,
      input  op, data, tag,
      output duv_ready, duv_valid, duv_error
   );

endinterface

// File: rtl/epw22_cmd_fifo.sv
// Synchronous FIFO of cmd_t with first-word-fall-through head.
//   clk, reset  : clock, asynchronous active-low reset
//   push        : write push_data (honoured when not full, or when a pop
//                 happens on the same edge)
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry, valid while !empty
//   full, empty : occupancy flags
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module epw22_cmd_fifo
   import epw22_cmd_issuer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  cmd_t push_data,
   input  logic pop,
   output cmd_t head,
   output logic full,
   output logic empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   cmd_t             mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_reg == FULL_CNT);
   assign empty = (count_reg == '0);
   assign head  = mem[rd_ptr_reg];

   // A pop frees the slot first, so push-while-full is legal with a pop.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/epw22_cmd_issuer.sv
// EPW22 command issuer: buffers whole commands and serialises them onto
// the ALU op/data/tag bus as one beat (A) or two contiguous beats (A, B).
//   clk, reset      : clock, asynchronous active-low reset
//   bus (master)    : command handshake in, ALU bus out, ALU status in
//   outstanding     : results issued but not yet returned
//   err_count       : duv_error rising edges plus spurious results (sat.)
//   illegal_count   : reserved opcodes dropped at the input (saturating)
//   idle            : FIFO empty, FSM idle and nothing outstanding
// The ALU must share this reset: a reset between beats A and B discards
// the half-issued command on both sides.
module epw22_cmd_issuer
   import epw22_cmd_issuer_pkg::*;
#(
   parameter  int FIFO_DEPTH      = 4,
   parameter  int MAX_OUTSTANDING = 8,
   parameter  int CNT_W           = 8,
   localparam int OUT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   epw22_cmd_issuer_if.master        bus,
   output logic [OUT_W-1:0]          outstanding,
   output logic [CNT_W-1:0]          err_count,
   output logic [CNT_W-1:0]          illegal_count,
   output logic                      idle
);

   localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

   // Command input and FIFO
   cmd_t in_cmd;
   cmd_t head;
   logic fifo_full;
   logic fifo_empty;
   logic accept;
   logic push_en;
   logic pop_en;

   // FSM state and registered bus outputs
   state_e            state_reg;
   logic [OP_W-1:0]   cur_op_reg;
   logic [DATA_W-1:0] cur_b_reg;
   logic [OP_W-1:0]   op_reg;
   logic [DATA_W-1:0] data_reg;
   logic [TAG_W-1:0]  tag_reg;

   // Status tracking
   logic [OUT_W-1:0] outstanding_reg;
   logic [CNT_W-1:0] err_count_reg;
   logic [CNT_W-1:0] illegal_count_reg;
   logic             valid_prev_reg;
   logic             error_prev_reg;
   logic             can_issue;
   logic             load_b;
   logic             inc;
   logic             dec;
   logic             spurious;
   logic             error_rise;
   logic [1:0]       err_add;
   logic [CNT_W:0]   err_sum;

   assign in_cmd = '{op: bus.cmd_op, tag: bus.cmd_tag, a: bus.cmd_a, b: bus.cmd_b};

   assign bus.cmd_ready = !fifo_full;
   assign accept        = bus.cmd_valid && !fifo_full;
   // Reserved opcodes complete the handshake but never reach the FIFO.
   assign push_en       = accept && !is_reserved(bus.cmd_op);

   epw22_cmd_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_en),
      .push_data (in_cmd),
      .pop       (pop_en),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // A result op is held back only when the in-flight limit is reached.
   // The count is bumped on the edge that loads the final beat, so the
   // registered value already covers anything this FSM has committed to.
   assign can_issue = !fifo_empty && bus.duv_ready &&
                      !(is_result_op(head.op) && (outstanding_reg == MAX_OUT));

   // A new command may start from IDLE, after a single-beat A, or after B.
   always_comb begin
      pop_en = 1'b0;
      if (can_issue) begin
         case (state_reg)
            ST_IDLE, ST_BEAT_B: pop_en = 1'b1;
            ST_BEAT_A:          pop_en = !is_two_beat(cur_op_reg);
            default:            pop_en = 1'b0;
         endcase
      end
   end

   assign load_b = bus.duv_ready &&
                   (((state_reg == ST_BEAT_A) && is_two_beat(cur_op_reg)) ||
                    (state_reg == ST_STALL_B));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= ST_IDLE;
         cur_op_reg <= '0;
         cur_b_reg  <= '0;
         op_reg     <= '0;
         data_reg   <= '0;
         tag_reg    <= '0;
      end else if (pop_en) begin
         state_reg  <= ST_BEAT_A;
         cur_op_reg <= head.op;
         cur_b_reg  <= head.b;
         op_reg     <= head.op;
         data_reg   <= head.a;
         tag_reg    <= head.tag;
      end else if (load_b) begin
         state_reg <= ST_BEAT_B;
         op_reg    <= cur_op_reg;
         data_reg  <= cur_b_reg;
      end else if ((state_reg == ST_STALL_B) ||
                   ((state_reg == ST_BEAT_A) && is_two_beat(cur_op_reg))) begin
         // Only op=0 between A and B keeps the ALU's pending-A state;
         // data and tag are left holding beat A.
         state_reg <= ST_STALL_B;
         op_reg    <= '0;
      end else begin
         state_reg <= ST_IDLE;
         op_reg    <= '0;
      end
   end

   assign bus.op   = op_reg;
   assign bus.data = data_reg;
   assign bus.tag  = tag_reg;

   // Final beat of a result op: beat A for single-beat ops, beat B otherwise.
   assign inc = (pop_en && is_result_op(head.op) && !is_two_beat(head.op)) ||
                (load_b && is_result_op(cur_op_reg));
   assign dec        = bus.duv_valid && !valid_prev_reg;
   assign error_rise = bus.duv_error && !error_prev_reg;
   // A result arriving with nothing outstanding is an error, unless an
   // issue on the same edge makes it legitimate.
   assign spurious   = dec && !inc && (outstanding_reg == '0);

   assign err_add = {1'b0, error_rise} + {1'b0, spurious};
   assign err_sum = {1'b0, err_count_reg} + (CNT_W+1)'(err_add);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_prev_reg    <= 1'b0;
         error_prev_reg    <= 1'b0;
         outstanding_reg   <= '0;
         err_count_reg     <= '0;
         illegal_count_reg <= '0;
      end else begin
         valid_prev_reg <= bus.duv_valid;
         error_prev_reg <= bus.duv_error;

         case ({inc, dec})
            2'b10: outstanding_reg <= outstanding_reg + OUT_W'(1);
            2'b01: begin
               if (outstanding_reg != '0) begin
                  outstanding_reg <= outstanding_reg - OUT_W'(1);
               end
            end
            default: outstanding_reg <= outstanding_reg;
         endcase

         err_count_reg <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];

         if (accept && is_reserved(bus.cmd_op) && (illegal_count_reg != '1)) begin
            illegal_count_reg <= illegal_count_reg + CNT_W'(1);
         end
      end
   end

   assign outstanding   = outstanding_reg;
   assign err_count     = err_count_reg;
   assign illegal_count = illegal_count_reg;
   assign idle          = fifo_empty && (state_reg == ST_IDLE) && (outstanding_reg == '0);

endmodule
